// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator. The counters advance on the pix_en strobe within the single clk domain.
// Optional VGA_OUT_REG_EN: pix_x/pix_y/hsync/vsync/video_on pass through one pixel-tick register stage, and line_end/frame_start are delayed to match.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 32'd640,
  parameter int unsigned H_FP     = 32'd16,
  parameter int unsigned H_SYNC   = 32'd96,
  parameter int unsigned H_BP     = 32'd48,
  parameter int unsigned V_ACTIVE = 32'd480,
  parameter int unsigned V_FP     = 32'd10,
  parameter int unsigned V_SYNC   = 32'd2,
  parameter int unsigned V_BP     = 32'd33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 32'd1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 32'd1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 32'd1);

  logic       r_armed;
  logic       r_running;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_tick;
  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_video;

  // r_armed swallows the first edge after reset release, so a strobe that coincides with release never counts.
  assign w_tick   = pix_en & r_armed;
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Next raster position: h wraps every line, v advances only on an h wrap.
  always_comb begin
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_h_last) begin
      w_h_next = 10'd0;
      if (w_v_last) begin
        w_v_next = 10'd0;
      end else begin
        w_v_next = r_v_cnt + 10'd1;
      end
    end else begin
      w_h_next = r_h_cnt + 10'd1;
      w_v_next = r_v_cnt;
    end
  end

  // Arm/run flags and the raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed   <= 1'b0;
      r_running <= 1'b0;
      r_h_cnt   <= 10'd0;
      r_v_cnt   <= 10'd0;
    end else begin
      r_armed <= 1'b1;
      if (w_tick) begin
        r_running <= 1'b1;
        r_h_cnt   <= w_h_next;
        r_v_cnt   <= w_v_next;
      end
    end
  end

  // Zero-latency decode of sync windows and the visible region.
  always_comb begin
    w_hsync = ~SYNC_POL;
    w_vsync = ~SYNC_POL;
    w_video = 1'b0;
    if ((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST)) begin
      w_hsync = SYNC_POL;
    end else begin
      w_hsync = ~SYNC_POL;
    end
    if ((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST)) begin
      w_vsync = SYNC_POL;
    end else begin
      w_vsync = ~SYNC_POL;
    end
    if (r_running && (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS)) begin
      w_video = 1'b1;
    end else begin
      w_video = 1'b0;
    end
  end

`ifdef VGA_OUT_REG_EN
  logic [9:0] r_x_q;
  logic [9:0] r_y_q;
  logic       r_hs_q;
  logic       r_vs_q;
  logic       r_vid_q;
  logic       r_fs_q;

  // Output stage: captures the decoded raster once per pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_q   <= 10'd0;
      r_y_q   <= 10'd0;
      r_hs_q  <= ~SYNC_POL;
      r_vs_q  <= ~SYNC_POL;
      r_vid_q <= 1'b0;
    end else if (w_tick) begin
      r_x_q   <= r_h_cnt;
      r_y_q   <= r_v_cnt;
      r_hs_q  <= w_hsync;
      r_vs_q  <= w_vsync;
      r_vid_q <= w_video;
    end
  end

  // Frame marker follows the delayed coordinates wrapping to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_q <= 1'b0;
    end else begin
      r_fs_q <= w_tick & (r_x_q == H_LAST) & (r_y_q == V_LAST);
    end
  end

  assign pix_x       = r_x_q;
  assign pix_y       = r_y_q;
  assign hsync       = r_hs_q;
  assign vsync       = r_vs_q;
  assign video_on    = r_vid_q;
  assign line_end    = w_tick & (r_x_q == H_LAST);
  assign frame_start = r_fs_q;
`else
  logic r_frame_start;

  // One-clk pulse after the edge that wraps both counters; reset never produces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick & w_h_last & w_v_last;
    end
  end

  assign pix_x       = r_h_cnt;
  assign pix_y       = r_v_cnt;
  assign hsync       = w_hsync;
  assign vsync       = w_vsync;
  assign video_on    = w_video;
  assign line_end    = w_tick & w_h_last;
  assign frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance plus a shrunken active-high-sync instance for frame-level behaviour.
`timescale 1ns/1ps
module tb_vga_sync_gen;
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
  localparam int S_FRAME = S_HT * (SV_A + SV_F + SV_S + SV_B);
  localparam int D_HT = 800;
  localparam int D_FRAME = 800 * 525;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic hs_d, vs_d, vid_d, le_d, fs_d;
  logic hs_s, vs_s, vid_s, le_s, fs_s;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: number of counting ticks since reset, plus arm/run flags.
  int   m_n;
  bit   m_armed, m_run, m_fs_d, m_fs_s;
  logic le_d_smp, le_s_smp, le_d_exp, le_s_exp;
  logic [9:0] x_d_pre;

  always #5 clk = ~clk;

  vga_sync_gen u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .pix_x(x_d), .pix_y(y_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(vid_d), .line_end(le_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .pix_x(x_s), .pix_y(y_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vid_s), .line_end(le_s), .frame_start(fs_s)
  );

  function automatic logic [22:0] raster(input int ha, hf, hs, hb, va, vf, vs, vb,
                                         input logic pol, input int n, input bit run);
    int ht, vt, x, y;
    logic h, v, vid;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    x   = n % ht;
    y   = (n / ht) % vt;
    h   = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
    v   = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
    vid = run && (x < ha) && (y < va);
    return {x[9:0], y[9:0], h, v, vid};
  endfunction

  function automatic logic [49:0] exp_all();
    return {raster(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, m_n, m_run), m_fs_d, le_d_exp,
            raster(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, m_n, m_run), m_fs_s, le_s_exp};
  endfunction

  function automatic logic [49:0] got_all();
    return {x_d, y_d, hs_d, vs_d, vid_d, fs_d, le_d_smp, x_s, y_s, hs_s, vs_s, vid_s, fs_s, le_s_smp};
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_armed = 1'b0;
    m_run = 1'b0;
    m_fs_d = 1'b0;
    m_fs_s = 1'b0;
    le_d_exp = 1'b0;
    le_s_exp = 1'b0;
  endtask

  // One clock: drive pix_en at negedge, capture line_end before the edge, advance the model at the edge.
  task automatic cycle(input logic pe);
    @(negedge clk);
    pix_en = pe;
    #1;
    le_d_smp = le_d;
    le_s_smp = le_s;
    x_d_pre  = x_d;
    le_d_exp = rst_n && pe && m_armed && ((m_n % D_HT) == D_HT - 1);
    le_s_exp = rst_n && pe && m_armed && ((m_n % S_HT) == S_HT - 1);
    @(posedge clk);
    m_fs_d = 1'b0;
    m_fs_s = 1'b0;
    if (rst_n) begin
      if (m_armed && pe) begin
        m_n++;
        m_run = 1'b1;
        m_fs_d = ((m_n % D_FRAME) == 0);
        m_fs_s = ((m_n % S_FRAME) == 0);
      end
      m_armed = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      n_tests++;
      if ({x_d, y_d, hs_d, vs_d, vid_d, le_d_smp, fs_d} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold_d got=%h/%h/%b%b%b%b%b want=0/0/11000", x_d, y_d, hs_d, vs_d, vid_d, le_d_smp, fs_d);
      end
      n_tests++;
      if ({x_s, y_s, hs_s, vs_s, vid_s, le_s_smp, fs_s} !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold_s got=%h/%h/%b%b%b%b%b want=0/0/00000", x_s, y_s, hs_s, vs_s, vid_s, le_s_smp, fs_s);
      end
    end
    rst_n = 1'b1;
    cycle(1'b1);
    n_tests++;
    if ({vid_d, x_d} !== {1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL release_edge1 got vid=%b x=%0d want vid=0 x=0", vid_d, x_d);
    end
    cycle(1'b1);
    n_tests++;
    if ({vid_d, x_d} !== {1'b1, 10'd1}) begin
      n_fail++;
      $display("FAIL release_edge2 got vid=%b x=%0d want vid=1 x=1", vid_d, x_d);
    end
    cycle(1'b1);
    n_tests++;
    if ({x_d, y_d} !== {10'd2, 10'd0}) begin
      n_fail++;
      $display("FAIL release_count got x=%0d y=%0d want x=2 y=0", x_d, y_d);
    end
  endtask

  task automatic test_line();
    int hs_low, hs_first, le_cnt, le_x;
    bit wrap_ok;
    hs_low = 0; hs_first = -1; le_cnt = 0; le_x = -1; wrap_ok = 1'b0;
    rst_n = 1'b0;
    model_reset();
    cycle(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 803; i++) begin
      cycle(1'b1);
      n_tests++;
      if (got_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL line_model i=%0d got=%h want=%h", i, got_all(), exp_all());
      end
      if (le_d_smp) begin
        le_cnt++;
        le_x = x_d_pre;
        wrap_ok = (x_d == 10'd0) && (y_d == 10'd1);
      end
      if (hs_d == 1'b0 && y_d == 10'd0) begin
        if (hs_low == 0) hs_first = x_d;
        hs_low++;
      end
    end
    n_tests++;
    if (hs_low != 96 || hs_first != 656) begin
      n_fail++;
      $display("FAIL line_hsync got width=%0d start=%0d want width=96 start=656", hs_low, hs_first);
    end
    n_tests++;
    if (le_cnt != 1 || le_x != 799 || !wrap_ok) begin
      n_fail++;
      $display("FAIL line_end got count=%0d at_x=%0d wrap=%0d want count=1 at_x=799 wrap=1", le_cnt, le_x, wrap_ok);
    end
  endtask

  task automatic test_strobe();
    int hs_low, run_len, bad_runs;
    bit first;
    logic [9:0] prev;
    hs_low = 0; run_len = 0; bad_runs = 0; first = 1'b1; prev = x_d;
    for (int i = 0; i < 3208; i++) begin
      cycle(((i % 4) == 0) ? 1'b1 : 1'b0);
      n_tests++;
      if (got_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL strobe_model i=%0d got=%h want=%h", i, got_all(), exp_all());
      end
      if (hs_d == 1'b0) hs_low++;
      if (x_d != prev) begin
        if (!first && run_len != 4) bad_runs++;
        first = 1'b0;
        run_len = 1;
        prev = x_d;
      end else begin
        run_len++;
      end
    end
    n_tests++;
    if (hs_low != 384) begin
      n_fail++;
      $display("FAIL strobe_hsync got width=%0d want 384", hs_low);
    end
    n_tests++;
    if (bad_runs != 0) begin
      n_fail++;
      $display("FAIL strobe_persist got bad_runs=%0d want 0", bad_runs);
    end
  endtask

  task automatic test_frame();
    int fs_cnt, fs_bad, vs_cnt, vs_bad;
    bit prev_fs;
    fs_cnt = 0; fs_bad = 0; vs_cnt = 0; vs_bad = 0; prev_fs = 1'b0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      cycle(1'b1);
      n_tests++;
      if (got_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL frame_model i=%0d got=%h want=%h", i, got_all(), exp_all());
      end
      if (fs_s) begin
        fs_cnt++;
        if (prev_fs || x_s != 10'd0 || y_s != 10'd0) fs_bad++;
      end
      prev_fs = fs_s;
      if (vs_s) begin
        vs_cnt++;
        if (y_s != 10'd5 && y_s != 10'd6) vs_bad++;
      end
    end
    n_tests++;
    if (fs_cnt != 2 || fs_bad != 0) begin
      n_fail++;
      $display("FAIL frame_start got pulses=%0d bad=%0d want pulses=2 bad=0", fs_cnt, fs_bad);
    end
    n_tests++;
    if (vs_cnt != 4 * S_HT || vs_bad != 0) begin
      n_fail++;
      $display("FAIL frame_vsync got clks=%0d bad=%0d want clks=%0d bad=0", vs_cnt, vs_bad, 4 * S_HT);
    end
  endtask

  task automatic test_midreset();
    rst_n = 1'b0;
    model_reset();
    cycle(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 80 && m_n < 3 * S_HT + 5; i++) cycle(1'b1);
    n_tests++;
    if ({x_s, y_s} !== {10'd5, 10'd3}) begin
      n_fail++;
      $display("FAIL midreset_pos got x=%0d y=%0d want x=5 y=3", x_s, y_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({x_s, y_s, vid_s, x_d, y_d, vid_d} !== {10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_async got s=%0d,%0d,%b d=%0d,%0d,%b want all zero", x_s, y_s, vid_s, x_d, y_d, vid_d);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      n_tests++;
      if ({fs_s, fs_d} !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_no_fs got fs_s=%b fs_d=%b want 00", fs_s, fs_d);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      n_tests++;
      if (got_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL random_model i=%0d got=%h want=%h", i, got_all(), exp_all());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_en = 1'b0;
    le_d_smp = 1'b0;
    le_s_smp = 1'b0;
    x_d_pre = 10'd0;
    model_reset();
    test_reset();
    test_line();
    test_strobe();
    test_frame();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480@60 VGA output path. It sits directly downstream of the pixel-clock divider and consumes that divider's 25 MHz pixel strobe as a clock enable, with all logic on the single system clock. It produces the horizontal and vertical counters, the sync pulses, the active-video flag and the frame/line markers that the pixel-colour logic and the VGA pins consume.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, single clock domain; all logic is clocked on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe from the divider; one-clk pulse per pixel, or held high
- pix_x  out  10  current horizontal count, 0..799
- pix_y  out  10  current vertical count, 0..524
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while pix_x < H_ACTIVE, pix_y < V_ACTIVE and running
- line_end  out  1  one-clk pulse on the last pixel of every line
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

## Operation
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Counters are unsigned, 10 bits.
- The counters change only on a clk edge where pix_en = 1. When pix_en = 0 all state holds.
- h_cnt: increments by one. On H_TOTAL-1 it wraps to 0.
- v_cnt: increments only on an h_cnt wrap. On V_TOTAL-1, coincident with an h_cnt wrap, it wraps to 0.
- hsync asserted (= SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]. Deasserted otherwise.
- vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]. Deasserted otherwise.
- running flag: cleared by reset; set on the first clk edge with pix_en = 1. video_on is gated by running.
- line_end = pix_en & (h_cnt == H_TOTAL-1). It is combinational on the enable tick and lasts one clk.
- frame_start: registered. It pulses for one clk after the edge on which both counters wrap to (0,0).
- Reset mid-frame: counters return to (0,0) immediately and asynchronously; running clears. frame_start does not pulse for a reset-induced return to (0,0).

## Timing
- Reset values: pix_x = 0, pix_y = 0, hsync = vsync = !SYNC_POL, video_on = 0, line_end = 0, frame_start = 0.
- Default build: pix_x/pix_y are the counter registers. hsync, vsync and video_on are decoded from them with zero latency.
- With pix_en held high, one line is 800 clks and one frame is 420000 clks.
- With the divider strobe at 1/4 of clk, each count lasts 4 clks. A line is then 3200 clks.
- pix_en asserted in the same cycle that rst_n deasserts: that edge is ignored. Counting starts on the next pix_en edge.

## Configuration
- VGA_OUT_REG_EN defined: hsync, vsync, video_on, pix_x and pix_y pass through one output register stage, clocked on pix_en edges.
  - These outputs lag the internal counters by exactly one pixel tick. All five stay mutually aligned.
  - line_end and frame_start are delayed by the same one pixel tick.
  - The register stage resets to the values listed under Timing.
- VGA_OUT_REG_EN undefined: the outputs are decoded combinationally from the counters, as described above.

## Test plan
- Reset held, then released with pix_en = 1 constantly -> outputs at reset values while held. video_on rises on the 2nd edge after release. pix_x counts 0,1,2,...
- pix_en constant high for one full line -> hsync is low for exactly 96 clks starting at pix_x = 656. line_end pulses once at pix_x = 799. pix_x then returns to 0 and pix_y becomes 1.
- pix_en pulsed 1-in-4 -> every pix_x value persists for 4 clks. There are no counts between strobes. The hsync width is 384 clks.
- Run to pix_y = 524, pix_x = 799 -> counters go to (0,0), frame_start pulses for exactly 1 clk, and vsync was low only for lines 490-491.
- Assert rst_n low at (pix_x,pix_y) = (300,200) -> counters are (0,0) in the same cycle with no clock edge. video_on = 0. No frame_start pulse.
- Build with VGA_OUT_REG_EN, pix_en high -> hsync falls when the internal count is 657 and the pix_x output reads 656. video_on falls one tick after the internal count reaches 640.
